// File: rtl/synth_bus_pkg.sv
// Types and constants shared by everything that drives the synth_engine parameter bus.
package synth_bus_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} arb_state_t;
    typedef enum logic {OWN_MIDI, OWN_CPU} bus_owner_t;

    // Bit positions inside the one-hot select vector {com, m2, m1, osc, env}.
    localparam int SEL_ENV = 0;
    localparam int SEL_OSC = 1;
    localparam int SEL_M1  = 2;
    localparam int SEL_M2  = 3;
    localparam int SEL_COM = 4;

    function automatic logic sel_valid(input logic [4:0] s);
        return $onehot(s);
    endfunction

endpackage

// File: rtl/utils.sv
// Shared elaboration-time helpers used across the synth codebase.
package utils;

    // Number of bits needed to encode values 0 .. value-1.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/param_req_port.sv
// One requester's side of the parameter bus: fields latched at grant, ack/err
// generation and a read-data register held until that requester's next ack.
module param_req_port
    import synth_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       grant,
    input  logic       done,
    input  logic       capture,
    input  logic       req_wr,
    input  logic [6:0] req_adr,
    input  logic [4:0] req_sel,
    input  logic       req_syx,
    input  logic [7:0] req_wdata,
    input  logic [7:0] bus_rdata,
    output logic       lat_wr,
    output logic [6:0] lat_adr,
    output logic [4:0] lat_sel,
    output logic       lat_syx,
    output logic [7:0] lat_wdata,
    output logic       sel_ok,
    output logic       ack,
    output logic       err,
    output logic [7:0] rdata_q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_wr    <= 1'b0;
            lat_adr   <= '0;
            lat_sel   <= '0;
            lat_syx   <= 1'b0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (grant) begin
                lat_wr    <= req_wr;
                lat_adr   <= req_adr;
                lat_sel   <= req_sel;
                lat_syx   <= req_syx;
                lat_wdata <= req_wdata;
            end
            if (capture) begin
                rdata_q <= bus_rdata;
            end
        end
    end

    assign sel_ok = sel_valid(lat_sel);
    assign ack    = done;
    assign err    = done & ~sel_ok;

endmodule

// File: rtl/param_bus_arbiter.sv
// Shares the synth_engine parameter bus between the MIDI decoder and the CPU port
// with a fixed SETUP / STROBE / DONE access sequence and bounded MIDI bursts.
module param_bus_arbiter
    import synth_bus_pkg::*;
#(
    parameter int ACCESS_CYCLES  = 4,
    parameter int MAX_MIDI_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    // Handshake: a requester raises req with stable fields and keeps them until
    // its one-cycle ack; fields are captured at grant, so a dropped req still
    // completes. Holding req across ack re-requests in the following IDLE cycle.
    input  logic       m_req,
    input  logic       m_wr,
    input  logic [6:0] m_adr,
    input  logic [4:0] m_sel,
    input  logic       m_syx,
    input  logic [7:0] m_wdata,
    output logic       m_ack,
    output logic       m_err,
    output logic [7:0] m_rdata,
    input  logic       c_req,
    input  logic       c_wr,
    input  logic [6:0] c_adr,
    input  logic [4:0] c_sel,
    input  logic       c_syx,
    input  logic [7:0] c_wdata,
    output logic       c_ack,
    output logic       c_err,
    output logic [7:0] c_rdata,
    output logic [6:0] adr,
    output logic [4:0] sel,
    output logic       write,
    output logic       read,
    output logic       sysex_data_patch_send,
    output logic [7:0] wdata,
    input  logic [7:0] rdata,
    output logic       owner,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int BW = utils::clogb2(MAX_MIDI_BURST + 1);

    arb_state_t state_q, state_d;
    bus_owner_t owner_q;
    logic [3:0]    cnt_q;
    logic [BW-1:0] burst_q;
    logic          grant_m, grant_c, last_strobe, strobe, is_cpu;

    logic       m_lat_wr, c_lat_wr, m_lat_syx, c_lat_syx, m_ok, c_ok;
    logic [6:0] m_lat_adr, c_lat_adr;
    logic [4:0] m_lat_sel, c_lat_sel;
    logic [7:0] m_lat_wdata, c_lat_wdata;
    logic       cur_wr, cur_ok;

    // MIDI has priority until it has used up its burst allowance against a waiting CPU.
    assign grant_m     = (state_q == IDLE) && m_req &&
                         !(c_req && (burst_q == BW'(MAX_MIDI_BURST)));
    assign grant_c     = (state_q == IDLE) && c_req && !grant_m;
    assign is_cpu      = (owner_q == OWN_CPU);
    assign strobe      = (state_q == STROBE);
    assign last_strobe = strobe && (cnt_q == 4'(ACCESS_CYCLES - 1));
    assign cur_wr      = is_cpu ? c_lat_wr : m_lat_wr;
    assign cur_ok      = is_cpu ? c_ok : m_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_m || grant_c) state_d = SETUP;
            SETUP:   state_d = cur_ok ? STROBE : DONE;
            STROBE:  if (last_strobe) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_MIDI;
            cnt_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_m) owner_q <= OWN_MIDI;
            if (grant_c) owner_q <= OWN_CPU;
            cnt_q <= strobe ? cnt_q + 4'd1 : 4'd0;
            if (state_q == IDLE) begin
                if (grant_c || !c_req) begin
                    burst_q <= '0;
                end else if (grant_m && (burst_q != BW'(MAX_MIDI_BURST))) begin
                    burst_q <= burst_q + 1'b1;
                end
            end
        end
    end

    param_req_port u_midi_port (
        .clk       (clk),
        .reset     (reset),
        .grant     (grant_m),
        .done      ((state_q == DONE) && !is_cpu),
        .capture   (last_strobe && !cur_wr && !is_cpu),
        .req_wr    (m_wr),
        .req_adr   (m_adr),
        .req_sel   (m_sel),
        .req_syx   (m_syx),
        .req_wdata (m_wdata),
        .bus_rdata (rdata),
        .lat_wr    (m_lat_wr),
        .lat_adr   (m_lat_adr),
        .lat_sel   (m_lat_sel),
        .lat_syx   (m_lat_syx),
        .lat_wdata (m_lat_wdata),
        .sel_ok    (m_ok),
        .ack       (m_ack),
        .err       (m_err),
        .rdata_q   (m_rdata)
    );

    param_req_port u_cpu_port (
        .clk       (clk),
        .reset     (reset),
        .grant     (grant_c),
        .done      ((state_q == DONE) && is_cpu),
        .capture   (last_strobe && !cur_wr && is_cpu),
        .req_wr    (c_wr),
        .req_adr   (c_adr),
        .req_sel   (c_sel),
        .req_syx   (c_syx),
        .req_wdata (c_wdata),
        .bus_rdata (rdata),
        .lat_wr    (c_lat_wr),
        .lat_adr   (c_lat_adr),
        .lat_sel   (c_lat_sel),
        .lat_syx   (c_lat_syx),
        .lat_wdata (c_lat_wdata),
        .sel_ok    (c_ok),
        .ack       (c_ack),
        .err       (c_err),
        .rdata_q   (c_rdata)
    );

    // Bus fields are forced to zero whenever no transaction is in flight.
    assign busy                  = (state_q != IDLE);
    assign owner                 = busy && is_cpu;
    assign adr                   = busy ? (is_cpu ? c_lat_adr : m_lat_adr) : '0;
    assign sel                   = busy ? (is_cpu ? c_lat_sel : m_lat_sel) : '0;
    assign wdata                 = busy ? (is_cpu ? c_lat_wdata : m_lat_wdata) : '0;
    assign sysex_data_patch_send = busy && (is_cpu ? c_lat_syx : m_lat_syx);
    assign write                 = strobe && cur_wr;
    assign read                  = strobe && !cur_wr;
    assign dbg_state             = state_q;

endmodule

// File: tb/tb_param_bus_arbiter.sv
// Directed bench for param_bus_arbiter at ACCESS_CYCLES = 4, MAX_MIDI_BURST = 4.
module tb_param_bus_arbiter;

    localparam int AC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       m_req, m_wr, m_syx, c_req, c_wr, c_syx;
    logic [6:0] m_adr, c_adr;
    logic [4:0] m_sel, c_sel;
    logic [7:0] m_wdata, c_wdata, rdata;
    logic       m_ack, m_err, c_ack, c_err;
    logic [7:0] m_rdata, c_rdata, wdata;
    logic [6:0] adr;
    logic [4:0] sel;
    logic       write, read, sysex_data_patch_send, owner, busy;
    logic [1:0] dbg_state;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    logic [7:0] m_rdata_exp = 8'h00;
    logic [7:0] c_rdata_exp = 8'h00;

    param_bus_arbiter #(.ACCESS_CYCLES(AC), .MAX_MIDI_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_wr(m_wr), .m_adr(m_adr), .m_sel(m_sel), .m_syx(m_syx),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .c_req(c_req), .c_wr(c_wr), .c_adr(c_adr), .c_sel(c_sel), .c_syx(c_syx),
        .c_wdata(c_wdata), .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
        .adr(adr), .sel(sel), .write(write), .read(read),
        .sysex_data_patch_send(sysex_data_patch_send), .wdata(wdata), .rdata(rdata),
        .owner(owner), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_adr"}, adr, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_syx"}, sysex_data_patch_send, 0);
        chk({tag, "_write"}, write, 0);
        chk({tag, "_read"}, read, 0);
        chk({tag, "_m_ack"}, m_ack, 0);
        chk({tag, "_c_ack"}, c_ack, 0);
        chk({tag, "_m_err"}, m_err, 0);
        chk({tag, "_c_err"}, c_err, 0);
        chk({tag, "_m_rdata"}, m_rdata, m_rdata_exp);
        chk({tag, "_c_rdata"}, c_rdata, c_rdata_exp);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // One complete access from the IDLE sample (cycle 0) to the IDLE after DONE.
    task automatic txn(input string tag, input bit cpu, input bit wr, input logic [6:0] a,
                       input logic [4:0] s, input bit syx, input logic [7:0] wd,
                       input logic [7:0] rd_bus, input int drop_at);
        bit valid;
        int last;
        bit exp_busy, exp_strobe, exp_ack;
        valid = $onehot(s);
        last  = valid ? AC + 2 : 2;
        rdata = rd_bus;
        if (cpu) begin
            c_wr = wr; c_adr = a; c_sel = s; c_syx = syx; c_wdata = wd; c_req = 1'b1; m_req = 1'b0;
        end else begin
            m_wr = wr; m_adr = a; m_sel = s; m_syx = syx; m_wdata = wd; m_req = 1'b1; c_req = 1'b0;
        end
        cyc = 0;
        for (int k = 1; k <= last + 1; k++) begin
            tick;
            exp_busy   = (k <= last);
            exp_strobe = valid && (k >= 2) && (k <= AC + 1);
            exp_ack    = (k == last);
            if (k == last && valid && !wr) begin
                if (cpu) c_rdata_exp = rd_bus;
                else     m_rdata_exp = rd_bus;
            end
            chk({tag, "_busy"}, busy, exp_busy);
            chk({tag, "_owner"}, owner, exp_busy && cpu);
            chk({tag, "_adr"}, adr, exp_busy ? a : 7'h00);
            chk({tag, "_sel"}, sel, exp_busy ? s : 5'h00);
            chk({tag, "_wdata"}, wdata, exp_busy ? wd : 8'h00);
            chk({tag, "_syx"}, sysex_data_patch_send, exp_busy && syx);
            chk({tag, "_write"}, write, exp_strobe && wr);
            chk({tag, "_read"}, read, exp_strobe && !wr);
            chk({tag, "_m_ack"}, m_ack, exp_ack && !cpu);
            chk({tag, "_c_ack"}, c_ack, exp_ack && cpu);
            chk({tag, "_m_err"}, m_err, exp_ack && !cpu && !valid);
            chk({tag, "_c_err"}, c_err, exp_ack && cpu && !valid);
            chk({tag, "_m_rdata"}, m_rdata, m_rdata_exp);
            chk({tag, "_c_rdata"}, c_rdata, c_rdata_exp);
            if (k == drop_at) begin
                m_req = 1'b0;
                c_req = 1'b0;
            end
            if (k == last) rdata = ~rd_bus;
        end
    endtask

    initial begin
        bit found;
        logic [9:0] cpu_turn;
        cpu_turn = 10'b10000_10000;

        reset = 1'b1;
        m_req = 0; m_wr = 0; m_adr = 0; m_sel = 0; m_syx = 0; m_wdata = 0;
        c_req = 0; c_wr = 0; c_adr = 0; c_sel = 0; c_syx = 0; c_wdata = 0;
        rdata = 8'h00;
        @(negedge clk);
        tick;
        chk_all_zero("reset");
        reset = 1'b0;
        tick;
        chk_all_zero("post_reset");

        txn("m_write", 0, 1, 7'h12, 5'b00001, 0, 8'hA5, 8'h00, AC + 2);
        txn("m_read",  0, 0, 7'h40, 5'b10000, 1, 8'h00, 8'h99, AC + 2);
        txn("c_read",  1, 0, 7'h05, 5'b00010, 0, 8'h00, 8'h3C, AC + 2);
        txn("m_badsel", 0, 1, 7'h07, 5'b00011, 0, 8'h11, 8'h00, 2);
        txn("c_zerosel", 1, 0, 7'h09, 5'b00000, 0, 8'h00, 8'h77, 2);
        txn("m_drop", 0, 1, 7'h21, 5'b00100, 1, 8'hC3, 8'h00, 2);

        // Both requesters held continuously: MIDI gets four grants, then CPU.
        m_wr = 1; m_adr = 7'h01; m_sel = 5'b00001; m_syx = 0; m_wdata = 8'h11;
        c_wr = 1; c_adr = 7'h02; c_sel = 5'b00100; c_syx = 0; c_wdata = 8'h22;
        m_req = 1; c_req = 1;
        for (int g = 0; g < 10; g++) begin
            found = 0;
            for (int c = 0; c < 20 && !found; c++) begin
                tick;
                if (dbg_state == 2'd1) found = 1;
            end
            chk("burst_grant_seen", found, 1);
            chk($sformatf("burst_owner_%0d", g), owner, cpu_turn[g]);
        end
        m_req = 0; c_req = 0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick;
            if (!busy) found = 1;
        end
        chk("burst_drain", found, 1);

        // Reset during cycle 3 of a write aborts it; the still-held request restarts.
        m_wr = 1; m_adr = 7'h33; m_sel = 5'b01000; m_syx = 1; m_wdata = 8'h5A; m_req = 1;
        cyc = 0;
        tick;
        tick;
        chk("abort_write_c2", write, 1);
        tick;
        chk("abort_write_c3", write, 1);
        reset = 1'b1;
        tick;
        m_rdata_exp = 8'h00;
        c_rdata_exp = 8'h00;
        chk_all_zero("abort");
        reset = 1'b0;
        txn("after_reset", 0, 1, 7'h33, 5'b01000, 1, 8'h5A, 8'h00, AC + 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
